// File: rtl/copy_stage_pkg.sv
// Shared field layout, FSM state and NCOPY clamp for the packet COPY stage.
package copy_stage_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } state_e;

  // Input layout, MSB first: {HDR, DEST, LR_MASK, FLAG, NCOPY, DATA}
  function automatic int unsigned ncopy_lsb(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned flag_lsb(int unsigned data_w, int unsigned cnt_w);
    return data_w + cnt_w;
  endfunction

  function automatic int unsigned lr_lsb(int unsigned data_w, int unsigned cnt_w);
    return data_w + cnt_w + 1;
  endfunction

  function automatic int unsigned dest_lsb(int unsigned data_w, int unsigned cnt_w,
                                           int unsigned max_copy);
    return data_w + cnt_w + 1 + max_copy;
  endfunction

  function automatic int unsigned in_w(int unsigned hdr_w, int unsigned dest_w,
                                       int unsigned max_copy, int unsigned cnt_w,
                                       int unsigned data_w);
    return hdr_w + dest_w + max_copy + 1 + cnt_w + data_w;
  endfunction

  function automatic int unsigned out_w(int unsigned hdr_w, int unsigned dest_w,
                                        int unsigned data_w);
    return hdr_w + dest_w + 2 + data_w;
  endfunction

  function automatic int unsigned clamp_ncopy(int unsigned ncopy, int unsigned max_copy);
    return (ncopy > max_copy - 1) ? max_copy - 1 : ncopy;
  endfunction

endpackage

// File: rtl/copy_stage_n_fmt.sv
// Combinational output formatter: destination offset by copy index and per-copy LR select.
module copy_pkt_fmt
  import copy_stage_pkg::*;
#(
  parameter int unsigned HDR_W    = 11,
  parameter int unsigned DEST_W   = 7,
  parameter int unsigned MAX_COPY = 2,
  parameter int unsigned CNT_W    = 1,
  parameter int unsigned DATA_W   = 18
) (
  input  logic [HDR_W+DEST_W+MAX_COPY+1+CNT_W+DATA_W-1:0] held_i,
  input  logic [$clog2(MAX_COPY)-1:0]                      idx_i,
  output logic [HDR_W+DEST_W+2+DATA_W-1:0]                 pkt_o
);

  localparam int unsigned IDX_W     = $clog2(MAX_COPY);
  localparam int unsigned NCOPY_LSB = ncopy_lsb(DATA_W);
  localparam int unsigned FLAG_LSB  = flag_lsb(DATA_W, CNT_W);
  localparam int unsigned LR_LSB    = lr_lsb(DATA_W, CNT_W);
  localparam int unsigned DEST_LSB  = dest_lsb(DATA_W, CNT_W, MAX_COPY);
  localparam int unsigned HDR_LSB   = DEST_LSB + DEST_W;

  logic [DEST_W-1:0]   dest_k;
  logic [MAX_COPY-1:0] lr_mask;
  logic [IDX_W-1:0]    lr_sel;
  logic                lr_k;
  logic                unused_ncopy;

  // The copy count has already been consumed at accept time.
  assign unused_ncopy = ^held_i[NCOPY_LSB +: CNT_W];

  always_comb begin
    lr_mask = held_i[LR_LSB +: MAX_COPY];
    lr_sel  = IDX_W'(MAX_COPY - 1) - idx_i;
    lr_k    = lr_mask[lr_sel];
    dest_k  = held_i[DEST_LSB +: DEST_W] + DEST_W'(idx_i);
    pkt_o   = {held_i[HDR_LSB +: HDR_W], dest_k, lr_k, held_i[FLAG_LSB], held_i[0 +: DATA_W]};
  end

endmodule

// File: rtl/copy_stage_n.sv
// Packet COPY stage: one accepted packet yields 1+NCOPY output packets over valid/ready.
module copy_stage_n
  import copy_stage_pkg::*;
#(
  parameter int unsigned HDR_W    = 11,
  parameter int unsigned DEST_W   = 7,
  parameter int unsigned MAX_COPY = 2,
  parameter int unsigned CNT_W    = 1,
  parameter int unsigned DATA_W   = 18
) (
  input  logic                                            CLK,
  input  logic                                            MR_N,
  input  logic                                            IN_VALID,
  output logic                                            IN_READY,
  input  logic [HDR_W+DEST_W+MAX_COPY+1+CNT_W+DATA_W-1:0] PACKET_IN,
  output logic                                            OUT_VALID,
  input  logic                                            OUT_READY,
  output logic [HDR_W+DEST_W+2+DATA_W-1:0]                PACKET_OUT,
  input  logic                                            COPY_EN,
  output logic                                            ERR_OVF,
  output logic                                            BUSY
);

  localparam int unsigned IN_W      = in_w(HDR_W, DEST_W, MAX_COPY, CNT_W, DATA_W);
  localparam int unsigned IDX_W     = $clog2(MAX_COPY);
  localparam int unsigned NCOPY_LSB = ncopy_lsb(DATA_W);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    held_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_q;
  logic               err_q;

  logic [CNT_W-1:0]   ncopy_in;
  logic [IDX_W-1:0]   last_in;
  logic               ovf_in;
  logic               at_last;
  logic               accept;

  always_comb begin
    ncopy_in = PACKET_IN[NCOPY_LSB +: CNT_W];
    ovf_in   = 32'(ncopy_in) > (MAX_COPY - 1);
    last_in  = COPY_EN ? IDX_W'(clamp_ncopy(32'(ncopy_in), MAX_COPY)) : '0;
    at_last  = (idx_q == last_q);
    IN_READY = (state_q == EMPTY) | ((state_q == EMIT) & OUT_READY & at_last);
    accept   = IN_VALID & IN_READY;
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (IN_VALID) state_d = EMIT;
      EMIT:    if (OUT_READY && at_last) state_d = IN_VALID ? EMIT : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    OUT_VALID = (state_q == EMIT);
    BUSY      = (state_q == EMIT);
    ERR_OVF   = err_q;
  end

  // Held packet and copy index; a new accept always restarts at copy 0.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      held_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & COPY_EN & ovf_in;
      if (accept) begin
        held_q <= PACKET_IN;
        idx_q  <= '0;
        last_q <= last_in;
      end else if ((state_q == EMIT) && OUT_READY && !at_last) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  copy_pkt_fmt #(
    .HDR_W    (HDR_W),
    .DEST_W   (DEST_W),
    .MAX_COPY (MAX_COPY),
    .CNT_W    (CNT_W),
    .DATA_W   (DATA_W)
  ) u_fmt (
    .held_i (held_q),
    .idx_i  (idx_q),
    .pkt_o  (PACKET_OUT)
  );

endmodule

// File: tb/tb_copy_stage_n.sv
// Scoreboard bench for copy_stage_n at default parameters and at MAX_COPY=4, CNT_W=3.
module tb_copy_stage_n;

  logic CLK = 1'b0;
  logic MR_N;
  always #5 CLK = ~CLK;

  logic        iv2, ir2, ov2, ordy2, ce2, err2, busy2;
  logic [39:0] pin2;
  logic [37:0] pout2;
  logic        iv4, ir4, ov4, ordy4, ce4, err4, busy4;
  logic [43:0] pin4;
  logic [37:0] pout4;

  copy_stage_n u_dut2 (
    .CLK(CLK), .MR_N(MR_N), .IN_VALID(iv2), .IN_READY(ir2), .PACKET_IN(pin2),
    .OUT_VALID(ov2), .OUT_READY(ordy2), .PACKET_OUT(pout2), .COPY_EN(ce2),
    .ERR_OVF(err2), .BUSY(busy2)
  );

  copy_stage_n #(.MAX_COPY(4), .CNT_W(3)) u_dut4 (
    .CLK(CLK), .MR_N(MR_N), .IN_VALID(iv4), .IN_READY(ir4), .PACKET_IN(pin4),
    .OUT_VALID(ov4), .OUT_READY(ordy4), .PACKET_OUT(pout4), .COPY_EN(ce4),
    .ERR_OVF(err4), .BUSY(busy4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int err_cnt4 = 0;
  logic [37:0] exp2[$];
  logic [37:0] exp4[$];
  int pop_cyc2[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk_in2(logic [10:0] h, logic [6:0] d, logic [1:0] m,
                                         logic f, logic n, logic [17:0] dat);
    return {h, d, m, f, n, dat};
  endfunction

  function automatic logic [43:0] mk_in4(logic [10:0] h, logic [6:0] d, logic [3:0] m,
                                         logic f, logic [2:0] n, logic [17:0] dat);
    return {h, d, m, f, n, dat};
  endfunction

  function automatic logic [37:0] mk_out(logic [10:0] h, logic [6:0] d, logic lr,
                                         logic f, logic [17:0] dat);
    return {h, d, lr, f, dat};
  endfunction

  // Monitors: pop and compare on every completed output handshake.
  always @(negedge CLK) begin
    if (MR_N && ov2 && ordy2) begin
      pop_cyc2.push_back(cyc);
      if (exp2.size() == 0) chk("dut2_unexpected_out", 64'(pout2), 64'(0));
      else chk("dut2_pkt", 64'(pout2), 64'(exp2.pop_front()));
    end
    if (MR_N && ov4 && ordy4) begin
      if (exp4.size() == 0) chk("dut4_unexpected_out", 64'(pout4), 64'(0));
      else chk("dut4_pkt", 64'(pout4), 64'(exp4.pop_front()));
    end
    if (MR_N && err4) err_cnt4++;
  end

  task automatic send2(input logic [39:0] p, input logic ce);
    logic ok;
    ok = 1'b0;
    iv2 = 1'b1; pin2 = p; ce2 = ce;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (ir2) ok = 1'b1;
    end
    chk("dut2_accept_timeout", 64'(ok), 64'(1));
    @(posedge CLK); #1;
    iv2 = 1'b0;
  endtask

  task automatic send4(input logic [43:0] p, input logic ce);
    logic ok;
    ok = 1'b0;
    iv4 = 1'b1; pin4 = p; ce4 = ce;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (ir4) ok = 1'b1;
    end
    chk("dut4_accept_timeout", 64'(ok), 64'(1));
    @(posedge CLK); #1;
    iv4 = 1'b0;
  endtask

  task automatic wait_idle2();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (exp2.size() == 0 && !ov2) ok = 1'b1;
    end
    chk("dut2_drain", 64'(ok), 64'(1));
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle4();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (exp4.size() == 0 && !ov4) ok = 1'b1;
    end
    chk("dut4_drain", 64'(ok), 64'(1));
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    MR_N = 1'b0;
    iv2 = 1'b0; pin2 = '0; ordy2 = 1'b1; ce2 = 1'b1;
    iv4 = 1'b0; pin4 = '0; ordy4 = 1'b1; ce4 = 1'b1;
    repeat (2) @(posedge CLK);
    #1 MR_N = 1'b1;

    @(negedge CLK);
    chk("rst_out_valid", 64'(ov2), 64'(0));
    chk("rst_busy", 64'(busy2), 64'(0));
    chk("rst_err", 64'(err2), 64'(0));
    chk("rst_in_ready", 64'(ir2), 64'(1));
    @(posedge CLK); #1;

    // Single packet, NCOPY=0
    exp2.push_back(mk_out(11'h5A5, 7'h10, 1'b1, 1'b1, 18'h21234));
    send2(mk_in2(11'h5A5, 7'h10, 2'b10, 1'b1, 1'b0, 18'h21234), 1'b1);
    chk("lat_out_valid", 64'(ov2), 64'(1));
    chk("lat_busy", 64'(busy2), 64'(1));
    @(posedge CLK); #1;
    chk("single_in_ready_after", 64'(ir2), 64'(1));
    chk("single_out_valid_after", 64'(ov2), 64'(0));
    wait_idle2();

    // NCOPY=1 with destination wrap
    exp2.push_back(mk_out(11'h0F0, 7'h7F, 1'b0, 1'b0, 18'h3FFFF));
    exp2.push_back(mk_out(11'h0F0, 7'h00, 1'b1, 1'b0, 18'h3FFFF));
    send2(mk_in2(11'h0F0, 7'h7F, 2'b01, 1'b0, 1'b1, 18'h3FFFF), 1'b1);
    wait_idle2();

    // COPY_EN=0 ignores NCOPY
    exp2.push_back(mk_out(11'h123, 7'h22, 1'b0, 1'b1, 18'h00ABC));
    send2(mk_in2(11'h123, 7'h22, 2'b01, 1'b1, 1'b1, 18'h00ABC), 1'b0);
    wait_idle2();

    // MAX_COPY=4: NCOPY=6 clamps to 3 copies and flags overflow
    err_cnt4 = 0;
    exp4.push_back(mk_out(11'h7FF, 7'h7E, 1'b1, 1'b0, 18'h15555));
    exp4.push_back(mk_out(11'h7FF, 7'h7F, 1'b0, 1'b0, 18'h15555));
    exp4.push_back(mk_out(11'h7FF, 7'h00, 1'b1, 1'b0, 18'h15555));
    exp4.push_back(mk_out(11'h7FF, 7'h01, 1'b0, 1'b0, 18'h15555));
    send4(mk_in4(11'h7FF, 7'h7E, 4'b1010, 1'b0, 3'd6, 18'h15555), 1'b1);
    chk("ovf_pulse_high", 64'(err4), 64'(1));
    @(posedge CLK); #1;
    chk("ovf_pulse_low", 64'(err4), 64'(0));
    wait_idle4();
    chk("ovf_pulse_count", 64'(err_cnt4), 64'(1));

    // NCOPY=3 exactly at the limit: no overflow
    exp4.push_back(mk_out(11'h2AA, 7'h40, 1'b0, 1'b1, 18'h00001));
    exp4.push_back(mk_out(11'h2AA, 7'h41, 1'b1, 1'b1, 18'h00001));
    exp4.push_back(mk_out(11'h2AA, 7'h42, 1'b0, 1'b1, 18'h00001));
    exp4.push_back(mk_out(11'h2AA, 7'h43, 1'b1, 1'b1, 18'h00001));
    send4(mk_in4(11'h2AA, 7'h40, 4'b0101, 1'b1, 3'd3, 18'h00001), 1'b1);
    wait_idle4();

    // COPY_EN=0 with out-of-range NCOPY: one packet, no overflow
    exp4.push_back(mk_out(11'h001, 7'h05, 1'b0, 1'b1, 18'h00000));
    send4(mk_in4(11'h001, 7'h05, 4'b0111, 1'b1, 3'd7, 18'h00000), 1'b0);
    wait_idle4();
    chk("ovf_count_after_no_ovf", 64'(err_cnt4), 64'(1));

    // Stall on copy 1 with the next packet waiting
    exp2.push_back(mk_out(11'h3C3, 7'h01, 1'b1, 1'b1, 18'h0BEEF));
    exp2.push_back(mk_out(11'h3C3, 7'h02, 1'b1, 1'b1, 18'h0BEEF));
    iv2 = 1'b1; ce2 = 1'b1;
    pin2 = mk_in2(11'h3C3, 7'h01, 2'b11, 1'b1, 1'b1, 18'h0BEEF);
    @(posedge CLK); #1;
    iv2 = 1'b0;
    @(posedge CLK); #1;
    ordy2 = 1'b0;
    exp2.push_back(mk_out(11'h111, 7'h30, 1'b0, 1'b0, 18'h00001));
    iv2 = 1'b1;
    pin2 = mk_in2(11'h111, 7'h30, 2'b00, 1'b0, 1'b0, 18'h00001);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_out_valid", 64'(ov2), 64'(1));
      chk("stall_pkt", 64'(pout2), 64'(mk_out(11'h3C3, 7'h02, 1'b1, 1'b1, 18'h0BEEF)));
      chk("stall_in_ready", 64'(ir2), 64'(0));
    end
    @(posedge CLK); #1;
    ordy2 = 1'b1;
    @(posedge CLK); #1;
    iv2 = 1'b0;
    wait_idle2();

    // Back-to-back A(NCOPY=1), B(NCOPY=0)
    pop_cyc2.delete();
    exp2.push_back(mk_out(11'h0AA, 7'h7E, 1'b1, 1'b1, 18'h2AAAA));
    exp2.push_back(mk_out(11'h0AA, 7'h7F, 1'b0, 1'b1, 18'h2AAAA));
    exp2.push_back(mk_out(11'h055, 7'h00, 1'b0, 1'b0, 18'h15555));
    send2(mk_in2(11'h0AA, 7'h7E, 2'b10, 1'b1, 1'b1, 18'h2AAAA), 1'b1);
    send2(mk_in2(11'h055, 7'h00, 2'b01, 1'b0, 1'b0, 18'h15555), 1'b1);
    wait_idle2();
    chk("b2b_count", 64'(pop_cyc2.size()), 64'(3));
    if (pop_cyc2.size() == 3) begin
      chk("b2b_gap01", 64'(pop_cyc2[1] - pop_cyc2[0]), 64'(1));
      chk("b2b_gap12", 64'(pop_cyc2[2] - pop_cyc2[1]), 64'(1));
    end

    // Reset during EMIT at copy 0 drops the packet
    ordy2 = 1'b0;
    iv2 = 1'b1;
    pin2 = mk_in2(11'h777, 7'h11, 2'b10, 1'b1, 1'b1, 18'h00003);
    @(posedge CLK); #1;
    iv2 = 1'b0;
    chk("pre_rst_out_valid", 64'(ov2), 64'(1));
    #2 MR_N = 1'b0;
    #1;
    chk("rst_async_out_valid", 64'(ov2), 64'(0));
    chk("rst_async_busy", 64'(busy2), 64'(0));
    @(posedge CLK); #1;
    MR_N = 1'b1;
    ordy2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_out_valid", 64'(ov2), 64'(0));
      chk("post_rst_in_ready", 64'(ir2), 64'(1));
    end

    chk("dut2_queue_empty", 64'(exp2.size()), 64'(0));
    chk("dut4_queue_empty", 64'(exp4.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
